// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-stage issue unit for the shared combinational ALU.
// Decodes one RV32I instruction per cycle (valid/ready), drives ALU operands
// and control, captures the returned result plus branch decision, and
// presents it downstream through a registered two-entry (OUT + SKID) buffer.
// Ports:
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready             input handshake (in_ready registered)
//   in_opcode/funct3/funct7_5     decoded instruction fields
//   in_rs1_val/rs2_val/imm/pc/rd  operands, immediate, PC, destination
//   alu_op_a/op_b/ctrl            combinational drive to the ALU
//   alu_result/alu_zero           combinational return from the ALU
//   out_valid/out_ready           output handshake
//   out_result/rd/wr_en           writeback fields
//   out_br_taken/br_target        branch decision and target
//   out_illegal                   unsupported opcode or funct3
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  output logic [XLEN-1:0] alu_op_a,
  output logic [XLEN-1:0] alu_op_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wr_en,
  output logic            out_br_taken,
  output logic [XLEN-1:0] out_br_target,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Entry layout: {illegal, br_target, br_taken, wr_en, rd, result}
  localparam int unsigned EW      = 2 * XLEN + 8;
  localparam int unsigned RD_LSB  = XLEN;
  localparam int unsigned WR_BIT  = XLEN + 5;
  localparam int unsigned TK_BIT  = XLEN + 6;
  localparam int unsigned TG_LSB  = XLEN + 7;
  localparam int unsigned ILL_BIT = 2 * XLEN + 7;

  // funct3/funct7 map shared by OP and OP-IMM; SUB only exists for OP.
  function automatic logic [3:0] arith_ctrl(input logic [2:0] f3,
                                            input logic       f7,
                                            input logic       is_reg);
    logic [3:0] c;
    c = ALU_ADD;
    case (f3)
      3'b000: c = (is_reg && f7) ? ALU_SUB : ALU_ADD;
      3'b001: c = ALU_SLL;
      3'b010: c = ALU_SLT;
      3'b011: c = ALU_SLTU;
      3'b100: c = ALU_XOR;
      3'b101: c = f7 ? ALU_SRA : ALU_SRL;
      3'b110: c = ALU_OR;
      3'b111: c = ALU_AND;
    endcase
    return c;
  endfunction

  logic            dec_wr;
  logic            dec_br;
  logic            dec_ill;
  logic            br_taken_c;
  logic [XLEN-1:0] br_target_c;
  logic [XLEN-1:0] result_c;
  logic [EW-1:0]   new_entry;

  // Operand select and ALU control decode.
  always_comb begin
    alu_op_a = '0;
    alu_op_b = '0;
    alu_ctrl = ALU_ADD;
    dec_wr   = 1'b0;
    dec_br   = 1'b0;
    dec_ill  = 1'b0;
    case (in_opcode)
      OPC_OP: begin
        alu_op_a = in_rs1_val;
        alu_op_b = in_rs2_val;
        alu_ctrl = arith_ctrl(in_funct3, in_funct7_5, 1'b1);
        dec_wr   = 1'b1;
      end
      OPC_OPIMM: begin
        alu_op_a = in_rs1_val;
        alu_op_b = in_imm;
        alu_ctrl = arith_ctrl(in_funct3, in_funct7_5, 1'b0);
        dec_wr   = 1'b1;
      end
      OPC_LUI: begin
        alu_op_b = in_imm;
        dec_wr   = 1'b1;
      end
      OPC_AUIPC: begin
        alu_op_a = in_pc;
        alu_op_b = in_imm;
        dec_wr   = 1'b1;
      end
      OPC_BRANCH: begin
        case (in_funct3)
          3'b000, 3'b001: alu_ctrl = ALU_SUB;
          3'b100, 3'b101: alu_ctrl = ALU_SLT;
          3'b110, 3'b111: alu_ctrl = ALU_SLTU;
          default:        dec_ill  = 1'b1;
        endcase
        if (!dec_ill) begin
          alu_op_a = in_rs1_val;
          alu_op_b = in_rs2_val;
          dec_br   = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // funct3[2] picks compare-result vs zero flag; funct3[0] inverts the sense.
  always_comb begin
    br_taken_c  = 1'b0;
    br_target_c = '0;
    result_c    = dec_ill ? '0 : alu_result;
    if (dec_br) begin
      br_taken_c  = (in_funct3[2] ? alu_result[0] : alu_zero) ^ in_funct3[0];
      br_target_c = XLEN'(in_pc + in_imm);
    end
  end

  assign new_entry = {dec_ill, br_target_c, br_taken_c, dec_wr, in_rd, result_c};

  logic [EW-1:0] out_q;
  logic [EW-1:0] skid_q;
  logic          skid_valid;
  logic [EW-1:0] out_d;
  logic [EW-1:0] skid_d;
  logic          out_valid_d;
  logic          skid_valid_d;
  logic          in_ready_d;
  logic          accept;
  logic          pop;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Skid-buffer next state; an accept can only happen while SKID is empty.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid;
    skid_valid_d = skid_valid;
    if (pop && skid_valid) begin
      out_d        = skid_q;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      if (!out_valid || (out_ready && !skid_valid)) begin
        out_d       = new_entry;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = new_entry;
        skid_valid_d = 1'b1;
      end
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_valid  <= out_valid_d;
      skid_valid <= skid_valid_d;
      in_ready   <= in_ready_d;
    end
  end

  assign out_result    = out_q[XLEN-1:0];
  assign out_rd        = out_q[RD_LSB +: 5];
  assign out_wr_en     = out_q[WR_BIT];
  assign out_br_taken  = out_q[TK_BIT];
  assign out_br_target = out_q[TG_LSB +: XLEN];
  assign out_illegal   = out_q[ILL_BIT];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, multi-cycle
// sequences (backpressure, mid-flight reset) and randomized traffic checked
// against an instruction-level reference model through an ordered scoreboard.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic [31:0] alu_op_a;
  logic [31:0] alu_op_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wr_en;
  logic        out_br_taken;
  logic [31:0] out_br_target;
  logic        out_illegal;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_pc(in_pc), .in_rd(in_rd),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en),
    .out_br_taken(out_br_taken), .out_br_target(out_br_target),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared external ALU.
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return {31'b0, $signed(a) < $signed(b)};
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: return 32'($signed(a) >>> b[4:0]);
      4'd9: return {31'b0, a < b};
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_ctrl, alu_op_a, alu_op_b);
    alu_zero   = (alu_result == 32'd0);
  end

  typedef struct packed {
    logic        ill;
    logic [31:0] tgt;
    logic        taken;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] result;
  } exp_t;

  // Instruction-level reference: what the instruction means, not how it is decoded.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] im, input logic [31:0] pc,
                                 input logic [4:0] rd);
    exp_t e;
    logic [31:0] b;
    e = '0;
    e.rd = rd;
    b = (op == 7'h33) ? r2 : im;
    case (op)
      7'h33, 7'h13: begin
        e.wr = 1'b1;
        case (f3)
          3'd0: e.result = (op == 7'h33 && f7) ? r1 - b : r1 + b;
          3'd1: e.result = r1 << b[4:0];
          3'd2: e.result = {31'b0, $signed(r1) < $signed(b)};
          3'd3: e.result = {31'b0, r1 < b};
          3'd4: e.result = r1 ^ b;
          3'd5: e.result = f7 ? 32'($signed(r1) >>> b[4:0]) : r1 >> b[4:0];
          3'd6: e.result = r1 | b;
          3'd7: e.result = r1 & b;
        endcase
      end
      7'h37: begin e.wr = 1'b1; e.result = im; end
      7'h17: begin e.wr = 1'b1; e.result = pc + im; end
      7'h63: begin
        if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
        else begin
          e.tgt = pc + im;
          case (f3)
            3'd0: begin e.taken = (r1 == r2); e.result = r1 - r2; end
            3'd1: begin e.taken = (r1 != r2); e.result = r1 - r2; end
            3'd4: begin e.taken = ($signed(r1) < $signed(r2));   e.result = {31'b0, e.taken}; end
            3'd5: begin e.taken = !($signed(r1) < $signed(r2));  e.result = {31'b0, !e.taken}; end
            3'd6: begin e.taken = (r1 < r2);   e.result = {31'b0, e.taken}; end
            default: begin e.taken = !(r1 < r2); e.result = {31'b0, !e.taken}; end
          endcase
        end
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] r1, r2, im, pc;
    logic [3:0]  x_ctrl;
    logic [31:0] x_a, x_b, x_res;
    logic        x_wr, x_tk;
    logic [31:0] x_tgt;
    logic        x_ill;
  } vec_t;

  int   checks;
  int   failures;
  exp_t sb[$];
  vec_t vecs[14];
  bit   done;

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] pc, input logic [4:0] rd);
    in_opcode = op; in_funct3 = f3; in_funct7_5 = f7;
    in_rs1_val = r1; in_rs2_val = r2; in_imm = im; in_pc = pc; in_rd = rd;
  endtask

  // Hold in_valid until accepted (sampled at negedge, taken at next posedge).
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] im, input logic [31:0] pc, input logic [4:0] rd);
    bit acc;
    acc = 1'b0;
    drive(op, f3, f7, r1, r2, im, pc, rd);
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 96'(acc), 96'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_empty", 96'(sb.size()), 96'd0);
  endtask

  initial begin
    logic [6:0] ops[7];
    exp_t e;
    exp_t got;
    checks = 0; failures = 0; done = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0);

    //          op     f3 f7 rs1           rs2       imm           pc            ctrl a             b             result        wr tk tgt           ill
    vecs[0]  = '{7'h33, 0, 0, 32'd10,       32'd5,    32'd0,        32'h100,      0, 32'd10,       32'd5,        32'd15,       1, 0, 32'h0,        0};
    vecs[1]  = '{7'h33, 0, 1, 32'd10,       32'd5,    32'd0,        32'h100,      1, 32'd10,       32'd5,        32'd5,        1, 0, 32'h0,        0};
    vecs[2]  = '{7'h33, 2, 0, 32'd10,       32'd5,    32'd0,        32'h100,      3, 32'd10,       32'd5,        32'd0,        1, 0, 32'h0,        0};
    vecs[3]  = '{7'h63, 0, 0, 32'd7,        32'd7,    32'h20,       32'h100,      1, 32'd7,        32'd7,        32'd0,        0, 1, 32'h120,      0};
    vecs[4]  = '{7'h63, 4, 0, 32'hFFFFFFFF, 32'd1,    32'h20,       32'h100,      3, 32'hFFFFFFFF, 32'd1,        32'd1,        0, 1, 32'h120,      0};
    vecs[5]  = '{7'h63, 6, 0, 32'hFFFFFFFF, 32'd1,    32'h20,       32'h100,      9, 32'hFFFFFFFF, 32'd1,        32'd0,        0, 0, 32'h120,      0};
    vecs[6]  = '{7'h00, 0, 0, 32'd10,       32'd5,    32'h20,       32'h100,      0, 32'd0,        32'd0,        32'd0,        0, 0, 32'h0,        1};
    vecs[7]  = '{7'h63, 2, 0, 32'd7,        32'd7,    32'h20,       32'h100,      0, 32'd0,        32'd0,        32'd0,        0, 0, 32'h0,        1};
    vecs[8]  = '{7'h17, 0, 0, 32'd1,        32'd2,    32'h20,       32'hFFFFFFF0, 0, 32'hFFFFFFF0, 32'h20,       32'h10,       1, 0, 32'h0,        0};
    vecs[9]  = '{7'h63, 0, 0, 32'd3,        32'd3,    32'h20,       32'hFFFFFFF0, 1, 32'd3,        32'd3,        32'd0,        0, 1, 32'h10,       0};
    vecs[10] = '{7'h37, 0, 0, 32'd99,       32'd5,    32'h12345000, 32'h100,      0, 32'd0,        32'h12345000, 32'h12345000, 1, 0, 32'h0,        0};
    vecs[11] = '{7'h13, 0, 1, 32'd10,       32'd5,    32'd3,        32'h100,      0, 32'd10,       32'd3,        32'd13,       1, 0, 32'h0,        0};
    vecs[12] = '{7'h13, 5, 1, 32'h80000000, 32'd5,    32'd4,        32'h100,      8, 32'h80000000, 32'd4,        32'hF8000000, 1, 0, 32'h0,        0};
    vecs[13] = '{7'h63, 1, 0, 32'd7,        32'd7,    32'h20,       32'h100,      1, 32'd7,        32'd7,        32'd0,        0, 0, 32'h120,      0};

    // Scoreboard: pop/compare on every transfer, push the model on every accept.
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (out_valid && out_ready) begin
            got = '{out_illegal, out_br_target, out_br_taken, out_wr_en, out_rd, out_result};
            if (sb.size() == 0) chk("unexpected_out", 96'(got), 96'd0 - 96'd1);
            else begin
              e = sb.pop_front();
              chk("sb_entry", 96'(got), 96'(e));
            end
          end
          if (in_valid && in_ready)
            sb.push_back(model(in_opcode, in_funct3, in_funct7_5, in_rs1_val, in_rs2_val,
                               in_imm, in_pc, in_rd));
        end
      end
    join_none

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 96'(out_valid), 96'd0);
    chk("rst_in_ready", 96'(in_ready), 96'd0);
    chk("rst_out_data", 96'({out_result, out_br_target, out_rd, out_wr_en, out_br_taken, out_illegal}), 96'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 96'(in_ready), 96'd1);

    // Directed vectors, one-cycle latency with out_ready high.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].r1, vecs[i].r2, vecs[i].im,
            vecs[i].pc, 5'(i + 1));
      in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_alu_ctrl", i), 96'(alu_ctrl), 96'(vecs[i].x_ctrl));
      chk($sformatf("v%0d_alu_ab", i), 96'({alu_op_a, alu_op_b}), 96'({vecs[i].x_a, vecs[i].x_b}));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), 96'(out_valid), 96'd1);
      chk($sformatf("v%0d_fields", i),
          96'({out_result, out_br_target, out_rd, out_wr_en, out_br_taken, out_illegal}),
          96'({vecs[i].x_res, vecs[i].x_tgt, 5'(i + 1), vecs[i].x_wr, vecs[i].x_tk, vecs[i].x_ill}));
    end
    drain();

    // Backpressure: two held, in_ready drops, then all four emerge in order.
    out_ready = 1'b0;
    send(7'h33, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1);
    chk("bp_ready_after_1", 96'(in_ready), 96'd1);
    send(7'h33, 3'd0, 1'b0, 32'd2, 32'd2, 32'd0, 32'd0, 5'd2);
    chk("bp_ready_after_2", 96'(in_ready), 96'd0);
    fork
      begin
        send(7'h33, 3'd0, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0, 5'd3);
        send(7'h33, 3'd0, 1'b0, 32'd4, 32'd4, 32'd0, 32'd0, 5'd4);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("bp_hold_ready", 96'(in_ready), 96'd0);
        chk("bp_hold_head", 96'({out_valid, out_rd, out_result}), 96'({1'b1, 5'd1, 32'd2}));
        out_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic with random backpressure.
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h03, 7'h00};
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [31:0] r1;
          logic [31:0] r2;
          logic [6:0]  op;
          if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
          r1 = $urandom;
          r2 = ($urandom_range(3) == 0) ? r1 : $urandom;
          op = ($urandom_range(9) == 0) ? 7'($urandom) : ops[$urandom_range(6)];
          send(op, 3'($urandom), 1'($urandom), r1, r2, $urandom, $urandom, 5'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom);
        end
      end
    join
    drain();

    // Reset with SKID full: both entries discarded, nothing stale afterwards.
    out_ready = 1'b0;
    send(7'h33, 3'd0, 1'b0, 32'd5, 32'd5, 32'd0, 32'd0, 5'd5);
    send(7'h33, 3'd0, 1'b0, 32'd6, 32'd6, 32'd0, 32'd0, 5'd6);
    chk("mr_skid_full", 96'(in_ready), 96'd0);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("mr_out_valid", 96'(out_valid), 96'd0);
    chk("mr_in_ready", 96'(in_ready), 96'd0);
    chk("mr_out_data", 96'({out_result, out_rd}), 96'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mr_ready_before_edge", 96'(in_ready), 96'd0);
    @(posedge clk);
    #1;
    chk("mr_ready_after_edge", 96'(in_ready), 96'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mr_no_stale_%0d", k), 96'(out_valid), 96'd0);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-stage issue unit that drives the shared combinational ALU. It accepts one decoded RV32I instruction per cycle over a valid/ready handshake and selects operands. It derives the 4-bit ALU control code, captures result and branch decision from the ALU's `result`/`zero` return path, and presents them downstream through a registered two-entry skid buffer. It sits between decode and writeback/PC-update.

## Interface
- `XLEN`, 32, datapath width.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1; `in_ready` out 1: input handshake.
- `in_opcode` in 7, `in_funct3` in 3, `in_funct7_5` in 1: decoded instruction fields.
- `in_rs1_val`, `in_rs2_val`, `in_imm`, `in_pc` in XLEN: operands, sign-extended immediate, instruction PC.
- `in_rd` in 5: destination register.
- `alu_op_a`, `alu_op_b` out XLEN; `alu_ctrl` out 4: combinational drive to ALU.
- `alu_result` in XLEN; `alu_zero` in 1: combinational return from ALU; `alu_zero` is 1 when `alu_result` is 0.
- `out_valid` out 1; `out_ready` in 1: output handshake.
- `out_result` out XLEN, `out_rd` out 5, `out_wr_en` out 1: writeback.
- `out_br_taken` out 1, `out_br_target` out XLEN, `out_illegal` out 1.

## Operation
- ALU codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 SLT, 0100 OR, 0101 XOR, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU.
- OP (0110011): a=rs1, b=rs2; funct3 000 → ADD, or SUB when funct7_5=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7_5=1; 110 OR; 111 AND. wr_en=1.
- OP-IMM (0010011): b=imm; same map, except funct3 000 is always ADD. funct7_5 selects SRA only for funct3 101. wr_en=1.
- LUI (0110111): a=0, b=imm, ADD. AUIPC (0010111): a=pc, b=imm, ADD. wr_en=1.
- BRANCH (1100011): a=rs1, b=rs2, wr_en=0, target=pc+imm, computed internally with XLEN wrap-around.
  - BEQ/BNE use SUB; taken = zero / !zero.
  - BLT/BGE use SLT; BLTU/BGEU use SLTU; taken = result[0] / !result[0].
  - funct3 010/011 → illegal.
- Any other opcode or illegal funct3: alu_ctrl=ADD, a=b=0; entry has illegal=1, wr_en=0, br_taken=0, result=0.
- Non-branch entries: br_taken=0, br_target=0.
- `alu_*` outputs depend only on `in_*` fields and are valid whenever `in_valid`=1. They are don't-care, but must be stable/deterministic, otherwise.

## Timing
- Accept when in_valid && in_ready; captured entry = {result, rd, wr_en, br_taken, br_target, illegal}.
- Two registers: OUT (drives out_*) and SKID.
- `in_ready` is registered and equals !skid_valid.
- On accept:
  - If OUT is empty, or out_ready=1 and SKID is empty → load OUT.
  - Else → load SKID.
- When out_valid && out_ready and SKID is full: OUT ← SKID and SKID empties, regardless of accept. An accept is impossible in that cycle since in_ready=0.
- Latency: accept in cycle N → out_valid in N+1. Throughput 1 per cycle when out_ready is held high.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- Output fields are stable while out_valid=1 and out_ready=0.
- Reset (async, any time including mid-transfer):
  - out_valid=0, skid_valid=0, in_ready=0 while rst=1, then 1 from the first clk edge after deassert.
  - All out_* data fields = 0.
  - In-flight entries are discarded.

## Test plan
- ADD/SUB/SLT: rs1=10, rs2=5; OP funct3 000/000+f7/010 → alu_ctrl 0000/0001/0011, out_result 15/5/0, wr_en=1, one cycle after accept.
- Branches: BEQ with rs1=rs2=7, pc=0x100, imm=0x20 → br_taken=1, target=0x120, wr_en=0. BLT with rs1=-1, rs2=1 → taken=1. BLTU with same operands → taken=0.
- Backpressure: issue 4 back-to-back with out_ready=0 → 2 held, in_ready drops after 2nd accept. Release out_ready → all 4 emerge in order, none lost.
- Illegal: opcode 0000000 and BRANCH funct3 010 → out_illegal=1, wr_en=0, br_taken=0, result=0.
- Wrap: AUIPC pc=0xFFFFFFF0, imm=0x20 → result 0x00000010. BEQ at same pc/imm → target 0x00000010.
- Reset mid-operation: assert rst with SKID full → out_valid=0 and in_ready=0 immediately. After deassert, in_ready=1 next edge and no stale entry appears.
